// File: rtl/out_port_fifo_if.sv
// CPU out-port to device bundle: write side, show-ahead read side and status.
// slave is the FIFO, master is whoever drives the CPU write and device ready.
interface out_port_fifo_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
);
   logic                       out_wr;
   logic [WIDTH-1:0]           out_data;
   logic                       dev_ready;
   logic                       dev_valid;
   logic [WIDTH-1:0]           dev_data;
   logic [$clog2(DEPTH):0]     count;
   logic                       full;
   logic                       empty;
   logic                       overflow;

   modport master (
      output out_wr, out_data, dev_ready,
      input  dev_valid, dev_data, count, full, empty, overflow
   );

   modport slave (
      input  out_wr, out_data, dev_ready,
      output dev_valid, dev_data, count, full, empty, overflow
   );
endinterface

// File: rtl/out_port_fifo.sv
// CPU out-port FIFO, show-ahead: a word written at edge N is on dev_data after N.
// Backpressure: full tells the CPU to stall; writes while full with no pop are dropped and flagged sticky.
module out_port_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic          clock,
   input  logic          reset,
   out_port_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             ovf;

   logic is_full;
   logic is_empty;
   logic do_push;
   logic do_pop;
   logic drop;

   assign is_full  = (cnt == FULL_CNT);
   assign is_empty = (cnt == '0);

   // Pop needs a head word, so a write into an empty queue is always a plain push.
   assign do_pop  = !is_empty && bus.dev_ready;
   assign do_push = bus.out_wr && (!is_full || do_pop);
   assign drop    = bus.out_wr && is_full && !do_pop;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CNT_ONE;
            2'b01:   cnt <= cnt - CNT_ONE;
            default: cnt <= cnt;
         endcase
         if (drop) ovf <= 1'b1;
      end
   end

   // Storage is never cleared; stale entries are hidden by the empty mask below.
   always_ff @(posedge clock) begin
      if (!reset && do_push) mem[wr_ptr] <= bus.out_data;
   end

   assign bus.dev_valid = !is_empty;
   assign bus.dev_data  = is_empty ? '0 : mem[rd_ptr];
   assign bus.count     = cnt;
   assign bus.full      = is_full;
   assign bus.empty     = is_empty;
   assign bus.overflow  = ovf;
endmodule

// File: tb/tb_out_port_fifo.sv
// Directed bench for out_port_fifo; accepted words go to a scoreboard queue, a monitor checks each pop.
module tb_out_port_fifo;
   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic clock;
   logic reset;

   out_port_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   out_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int rx_cnt = 0;
   int mcnt   = 0;
   bit in_stream = 1'b0;
   logic [WIDTH-1:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: inputs are stable at the falling edge, so a valid&&ready seen here is the pop of the next edge.
   always @(negedge clock) begin
      if (!reset && bus.dev_valid === 1'b1 && bus.dev_ready === 1'b1) begin
         rx_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: got 0x%0h expected nothing at %0t", bus.dev_data, $time);
         end else begin
            check("pop_data", bus.dev_data, exp_q.pop_front());
         end
      end
      if (in_stream) begin
         checks++;
         if (bus.count > 3'd1) begin
            errors++;
            $display("FAIL stream_count: got %0d expected at most 1", bus.count);
         end
      end
   end

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   // One clock with the given inputs; the expected queue follows the behavioural FIFO rules.
   task automatic step(input logic wr, input logic [WIDTH-1:0] data, input logic rdy);
      bit pop;
      bit push;
      bus.out_wr    = wr;
      bus.out_data  = data;
      bus.dev_ready = rdy;
      pop  = rdy && (mcnt > 0);
      push = wr && ((mcnt < DEPTH) || pop);
      if (push) exp_q.push_back(data);
      mcnt = mcnt + int'(push) - int'(pop);
      cycle();
      bus.out_wr    = 1'b0;
      bus.out_data  = '0;
      bus.dev_ready = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.out_wr    = 1'b1;
      bus.out_data  = 32'hDEAD_BEEF;
      bus.dev_ready = 1'b1;
      cycle();
      reset = 1'b0;
      bus.out_wr    = 1'b0;
      bus.out_data  = '0;
      bus.dev_ready = 1'b0;
      exp_q.delete();
      mcnt = 0;
   endtask

   initial begin
      int rx_before;
      reset = 1'b1;
      bus.out_wr    = 1'b0;
      bus.out_data  = '0;
      bus.dev_ready = 1'b0;
      cycle();
      cycle();
      do_reset();

      check("rst_count", bus.count, 0);
      check("rst_valid", bus.dev_valid, 0);
      check("rst_data", bus.dev_data, 0);
      check("rst_empty", bus.empty, 1);
      check("rst_full", bus.full, 0);
      check("rst_overflow", bus.overflow, 0);

      // First push becomes visible the cycle after its edge.
      step(1'b1, 32'h1111_1111, 1'b0);
      check("first_valid", bus.dev_valid, 1);
      check("first_data", bus.dev_data, 32'h1111_1111);
      check("first_count", bus.count, 1);
      check("first_empty", bus.empty, 0);
      step(1'b0, '0, 1'b1);
      check("first_drained_empty", bus.empty, 1);

      // Fill, overflow on fifth word, drain in order.
      step(1'b1, 32'hA, 1'b0);
      step(1'b1, 32'hB, 1'b0);
      step(1'b1, 32'hC, 1'b0);
      step(1'b1, 32'hD, 1'b0);
      check("fill_count", bus.count, 4);
      check("fill_full", bus.full, 1);
      check("fill_overflow", bus.overflow, 0);
      step(1'b1, 32'hE, 1'b0);
      check("drop_overflow", bus.overflow, 1);
      check("drop_count", bus.count, 4);
      check("drop_head", bus.dev_data, 32'hA);
      rx_before = rx_cnt;
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
      check("drain_rx", rx_cnt - rx_before, 4);
      check("drain_empty", bus.empty, 1);
      check("drain_overflow_sticky", bus.overflow, 1);
      check("drain_data_zero", bus.dev_data, 0);

      // Push and pop together while full.
      step(1'b1, 32'hA, 1'b0);
      step(1'b1, 32'hB, 1'b0);
      step(1'b1, 32'hC, 1'b0);
      step(1'b1, 32'hD, 1'b0);
      step(1'b1, 32'h55, 1'b1);
      check("fullpp_count", bus.count, 4);
      check("fullpp_full", bus.full, 1);
      check("fullpp_overflow", bus.overflow, 1);
      check("fullpp_head", bus.dev_data, 32'hB);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
      check("fullpp_empty", bus.empty, 1);

      // Continuous stream, pointers wrap twice.
      rx_before = rx_cnt;
      in_stream = 1'b1;
      for (int i = 1; i <= 10; i++) step(1'b1, WIDTH'(i), 1'b1);
      step(1'b0, '0, 1'b1);
      in_stream = 1'b0;
      check("stream_rx", rx_cnt - rx_before, 10);
      check("stream_empty", bus.empty, 1);

      // Reset with words stored and overflow set.
      step(1'b1, 32'h21, 1'b0);
      step(1'b1, 32'h22, 1'b0);
      step(1'b1, 32'h23, 1'b0);
      check("prerst_count", bus.count, 3);
      check("prerst_overflow", bus.overflow, 1);
      do_reset();
      check("midrst_count", bus.count, 0);
      check("midrst_valid", bus.dev_valid, 0);
      check("midrst_data", bus.dev_data, 0);
      check("midrst_overflow", bus.overflow, 0);
      step(1'b1, 32'h77, 1'b0);
      check("postrst_head", bus.dev_data, 32'h77);
      check("postrst_count", bus.count, 1);
      step(1'b0, '0, 1'b1);

      // Ready while empty must be inert.
      for (int i = 0; i < 5; i++) begin
         step(1'b0, '0, 1'b1);
         check("idle_count", bus.count, 0);
         check("idle_valid", bus.dev_valid, 0);
      end
      check("idle_overflow", bus.overflow, 0);
      step(1'b1, 32'h99, 1'b0);
      check("idle_next_head", bus.dev_data, 32'h99);
      check("idle_next_count", bus.count, 1);
      step(1'b0, '0, 1'b1);

      cycle();
      check("scoreboard_leftover", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/out_port_fifo.md
OUT_PORT_FIFO -- requirements
Module: out_port_fifo

Interface
REQ-001 Parameter WIDTH, default 32, data word width (matches the CPU out-port register).
REQ-002 Parameter DEPTH, default 4, number of entries; SHALL be a power of two, at least 2.
REQ-003 clock  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 out_wr  input  1  CPU out-port write strobe; one word offered per high cycle.
REQ-006 out_data  input  WIDTH  CPU out-port data, qualified by out_wr.
REQ-007 dev_ready  input  1  external device accepts the head word this cycle.
REQ-008 dev_valid  output  1  head word present on dev_data.
REQ-009 dev_data  output  WIDTH  head-of-queue word; 0 when empty.
REQ-010 count  output  log2(DEPTH)+1  number of stored words, 0..DEPTH.
REQ-011 full  output  1  count == DEPTH; CPU control uses it to stall further out-port writes.
REQ-012 empty  output  1  count == 0.
REQ-013 overflow  output  1  sticky flag; a write was dropped.

Function
REQ-014 Storage SHALL be a circular buffer with write and read pointers of log2(DEPTH) bits, each wrapping from DEPTH-1 to 0.
REQ-015 Push condition: out_wr && (!full || pop); push writes out_data at the write pointer and advances it by 1.
REQ-016 Pop condition: dev_valid && dev_ready; pop advances the read pointer by 1.
REQ-017 dev_ready while empty SHALL have no effect: no pointer, count or flag change.
REQ-018 dev_valid SHALL equal !empty.
REQ-019 dev_data SHALL be the entry at the read pointer (show-ahead) whenever dev_valid=1.
REQ-020 Latency: a word pushed at edge N SHALL appear on dev_data/dev_valid in the cycle after edge N if the queue was empty.
REQ-021 Ordering SHALL be strictly first-in first-out; no word is duplicated or reordered.
REQ-022 Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
REQ-023 Simultaneous push and pop while full SHALL both occur; count stays DEPTH and full stays 1.
REQ-024 Simultaneous push and pop while empty SHALL be impossible, because pop requires dev_valid; push alone occurs.
REQ-025 out_wr while full without a pop SHALL drop the word: storage, pointers and count unchanged; overflow set to 1 at that edge.
REQ-026 overflow SHALL remain 1 until reset; no other input clears it.
REQ-027 full, empty and dev_valid SHALL be derived combinationally from count, so they are consistent with count in every cycle.
REQ-028 The block SHALL contain no combinational path from out_wr or out_data to dev_valid or dev_data.

Reset
REQ-029 While reset=1 at an edge:
  - pointers and count SHALL clear to 0; overflow SHALL clear to 0.
  - resulting outputs: dev_valid=0, dev_data=0, empty=1, full=0.
  - out_wr and dev_ready SHALL be ignored in that cycle.
REQ-030 Reset mid-operation SHALL discard all stored words; storage contents need not be cleared.
REQ-031 The first push after reset deasserts SHALL land at entry 0.

Verification
REQ-032 Reset, then push 0x11111111, with dev_ready=0 -> next cycle dev_valid=1, dev_data=0x11111111, count=1, empty=0.
REQ-033 Push 0xA, 0xB, 0xC, 0xD with dev_ready=0 -> count=4, full=1; fifth push 0xE -> overflow=1, count=4; then drain with dev_ready=1 -> output sequence 0xA, 0xB, 0xC, 0xD, then empty=1, overflow still 1.
REQ-034 Full queue, push 0x55 while dev_ready=1 in the same cycle -> 0xA popped, 0x55 stored, count=4, overflow unchanged; later drain ends with 0x55.
REQ-035 Continuous stream of 10 pushes (0x1..0xA) with dev_ready=1 every cycle -> all 10 received in order, count never above 1, pointers wrap twice.
REQ-036 Queue holding 3 words with overflow=1, assert reset for one edge -> count=0, dev_valid=0, dev_data=0, overflow=0; next push 0x77 appears as head.
REQ-037 Empty queue, dev_ready=1 for 5 cycles with no push -> count stays 0, no underflow, dev_valid stays 0.
